// File: rtl/quad_encoder.sv
// Quadrature encoder decoder with input synchronization, per-channel glitch
// filtering, a small start-up sequencer and a signed position accumulator.
//
// Parameters:
//   POS_WIDTH     - width of the signed position counter
//   FILTER_CYCLES - consecutive stable cycles (1..15) needed to accept a
//                   channel level change
//
// Ports:
//   CLK       - system clock, all state on the rising edge
//   resetn    - asynchronous active-low reset
//   ENC_A/B   - raw asynchronous encoder pad inputs
//   pos_load  - load pos_val into position this cycle
//   pos_val   - value used by pos_load
//   clr_err   - clears the sticky error flag
//   position  - signed accumulated count (registered)
//   step      - one-cycle pulse per accepted quadrature edge
//   dir       - direction of the most recent step, 1 = forward
//   err       - sticky flag for transitions where both channels changed
//   ready     - high while the decoder is running
module quad_encoder #(
    parameter int POS_WIDTH     = 32,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic                        ENC_A,
    input  logic                        ENC_B,
    input  logic                        pos_load,
    input  logic signed [POS_WIDTH-1:0] pos_val,
    input  logic                        clr_err,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        step,
    output logic                        dir,
    output logic                        err,
    output logic                        ready
);

    typedef enum logic [1:0] {
        SYNC_WAIT,
        PRIME,
        RUN
    } state_t;

    localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        wait_cnt;

    // Index 1 carries channel A, index 0 carries channel B.
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  filt;
    logic [3:0]  filt_cnt [2];
    logic [1:0]  prev_ab;

    logic        fwd_edge;
    logic        rev_edge;
    logic        bad_edge;

    // Two-flop synchronizers for the asynchronous pad inputs.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {ENC_A, ENC_B};
            sync2 <= sync1;
        end
    end

    // Glitch filters: a level is accepted on the FILTER_CYCLES-th
    // consecutive cycle of disagreement; any agreement restarts the count.
    // PRIME seeds the filters straight from the synchronized levels so the
    // first RUN cycle never sees a spurious change.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            filt <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                filt_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state == PRIME) begin
                    filt[i]     <= sync2[i];
                    filt_cnt[i] <= 4'd0;
                end else if (sync2[i] != filt[i]) begin
                    if (filt_cnt[i] == FILT_LAST) begin
                        filt[i]     <= sync2[i];
                        filt_cnt[i] <= 4'd0;
                    end else begin
                        filt_cnt[i] <= filt_cnt[i] + 4'd1;
                    end
                end else begin
                    filt_cnt[i] <= 4'd0;
                end
            end
        end
    end

    // Control state register plus the two-cycle settle counter used while
    // the synchronizers fill after reset.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state    <= SYNC_WAIT;
            wait_cnt <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == SYNC_WAIT) ? (wait_cnt + 1'b1) : 1'b0;
        end
    end

    // Next-state logic: SYNC_WAIT for two cycles, PRIME for one, then RUN.
    always_comb begin
        next_state = state;
        case (state)
            SYNC_WAIT: if (wait_cnt) next_state = PRIME;
            PRIME:     next_state = RUN;
            RUN:       next_state = RUN;
            default:   next_state = SYNC_WAIT;
        endcase
    end

    // Quadrature decode of previous vs. current filtered state. Forward
    // follows 00->10->11->01->00; a change of both bits is illegal.
    always_comb begin
        fwd_edge = 1'b0;
        rev_edge = 1'b0;
        bad_edge = 1'b0;
        if (state == RUN) begin
            case ({prev_ab, filt})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd_edge = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev_edge = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: bad_edge = 1'b1;
                default: ;
            endcase
        end
    end

    // Position, step, direction and error registers. A load wins over a
    // simultaneous step for the count, while step/dir still report the edge.
    // A new illegal transition wins over clr_err.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            prev_ab  <= 2'b00;
            position <= '0;
            step     <= 1'b0;
            dir      <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state == PRIME) begin
                prev_ab <= sync2;
            end else if (state == RUN) begin
                prev_ab <= filt;
            end

            if (pos_load) begin
                position <= pos_val;
            end else if (fwd_edge) begin
                position <= position + POS_WIDTH'(1);
            end else if (rev_edge) begin
                position <= position - POS_WIDTH'(1);
            end

            step <= fwd_edge | rev_edge;

            if (fwd_edge) begin
                dir <= 1'b1;
            end else if (rev_edge) begin
                dir <= 1'b0;
            end

            if (bad_edge) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

    assign ready = (state == RUN);

endmodule

// File: tb/tb_quad_encoder.sv
// Self-checking bench for quad_encoder at default parameters. A behavioural
// model tracks the pad state as a position on the four-step Gray cycle and
// predicts position/dir/err/step from the documented 7-edge latency.
module tb_quad_encoder;

    logic        CLK;
    logic        resetn;
    logic        ENC_A;
    logic        ENC_B;
    logic        pos_load;
    logic [31:0] pos_val;
    logic        clr_err;
    logic [31:0] position;
    logic        step;
    logic        dir;
    logic        err;
    logic        ready;

    int tests_run    = 0;
    int tests_failed = 0;
    int steps_seen   = 0;

    logic [31:0] m_pos;
    logic        m_dir;
    logic        m_err;
    logic [1:0]  m_ab;
    logic [1:0]  gcode [4];

    quad_encoder dut (
        .CLK      (CLK),
        .resetn   (resetn),
        .ENC_A    (ENC_A),
        .ENC_B    (ENC_B),
        .pos_load (pos_load),
        .pos_val  (pos_val),
        .clr_err  (clr_err),
        .position (position),
        .step     (step),
        .dir      (dir),
        .err      (err),
        .ready    (ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Position of a pad state within the forward cycle 00,10,11,01.
    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pos"}, 64'(position), 64'(m_pos));
        check({tag, "_dir"}, 64'(dir), 64'(m_dir));
        check({tag, "_err"}, 64'(err), 64'(m_err));
    endtask

    task automatic load(input logic [31:0] val);
        pos_load = 1'b1;
        pos_val  = val;
        tick();
        pos_load = 1'b0;
        m_pos    = val;
        check("load_pos", 64'(position), 64'(m_pos));
    endtask

    // Drive a new pad state and verify the decoded result on the 7th edge,
    // with optional pos_load / clr_err coinciding with that edge.
    task automatic move(input logic [1:0] new_ab, input bit do_load,
                        input logic [31:0] load_val, input bit do_clr);
        int   d;
        logic exp_step;
        d = (gidx(new_ab) - gidx(m_ab)) & 3;
        {ENC_A, ENC_B} = new_ab;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("early_step", 64'(step), 64'(0));
        end
        check("early_pos", 64'(position), 64'(m_pos));
        if (do_load) begin
            pos_load = 1'b1;
            pos_val  = load_val;
        end
        if (do_clr) clr_err = 1'b1;
        tick();
        pos_load = 1'b0;
        clr_err  = 1'b0;
        exp_step = 1'b0;
        if (d == 1) begin
            m_pos    = m_pos + 32'd1;
            m_dir    = 1'b1;
            exp_step = 1'b1;
        end else if (d == 3) begin
            m_pos    = m_pos - 32'd1;
            m_dir    = 1'b0;
            exp_step = 1'b1;
        end
        if (do_load) m_pos = load_val;
        if (d == 2) m_err = 1'b1;
        else if (do_clr) m_err = 1'b0;
        if (step) steps_seen++;
        check("edge_step", 64'(step), 64'(exp_step));
        check_all("edge");
        for (int i = 8; i <= 10; i++) begin
            tick();
            check("late_step", 64'(step), 64'(0));
        end
        m_ab = new_ab;
    endtask

    initial begin
        int          r;
        int          steps_before;
        logic [1:0]  nab;

        gcode[0] = 2'b00;
        gcode[1] = 2'b10;
        gcode[2] = 2'b11;
        gcode[3] = 2'b01;

        // Reset held with pads at 11.
        resetn   = 1'b0;
        ENC_A    = 1'b1;
        ENC_B    = 1'b1;
        pos_load = 1'b0;
        pos_val  = 32'd0;
        clr_err  = 1'b0;
        m_pos    = 32'd0;
        m_dir    = 1'b0;
        m_err    = 1'b0;
        m_ab     = 2'b11;
        tick();
        tick();
        check_all("reset");
        check("reset_step", 64'(step), 64'(0));
        check("reset_ready", 64'(ready), 64'(0));

        // Release: ready appears on the third edge, nothing else moves.
        resetn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("start_ready", 64'(ready), 64'(i >= 3));
            check("start_step", 64'(step), 64'(0));
            check_all("start");
        end

        // Walk forward to 00, zero the count, then four forward edges.
        move(2'b01, 0, 32'd0, 0);
        move(2'b00, 0, 32'd0, 0);
        load(32'd0);
        steps_before = steps_seen;
        move(2'b10, 0, 32'd0, 0);
        move(2'b11, 0, 32'd0, 0);
        move(2'b01, 0, 32'd0, 0);
        move(2'b00, 0, 32'd0, 0);
        check("fwd4_pos", 64'(position), 64'(4));
        check("fwd4_steps", 64'(steps_seen - steps_before), 64'(4));
        check("fwd4_dir", 64'(dir), 64'(1));

        // Three-cycle glitch on A must be rejected.
        ENC_A = 1'b1;
        tick();
        tick();
        tick();
        ENC_A = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("glitch_step", 64'(step), 64'(0));
        end
        check_all("glitch");

        // Wrap in both directions.
        load(32'h7FFF_FFFF);
        move(2'b10, 0, 32'd0, 0);
        check("wrap_up", 64'(position), 64'h8000_0000);
        move(2'b00, 0, 32'd0, 0);
        check("wrap_down", 64'(position), 64'h7FFF_FFFF);
        load(32'h8000_0000);
        move(2'b01, 0, 32'd0, 0);
        check("wrap_min", 64'(position), 64'h7FFF_FFFF);
        move(2'b00, 0, 32'd0, 0);

        // Load coinciding with a forward edge: load wins, step/dir still set.
        move(2'b10, 1, 32'h0000_1234, 0);
        move(2'b00, 0, 32'd0, 0);

        // Illegal transitions and sticky error behaviour.
        move(2'b11, 0, 32'd0, 0);
        check("illegal_err", 64'(err), 64'(1));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_err   = 1'b0;
        check("clr_err", 64'(err), 64'(0));
        move(2'b00, 0, 32'd0, 1);
        check("clr_vs_set", 64'(err), 64'(1));

        // Randomized walk checked against the model.
        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       nab = gcode[(gidx(m_ab) + 1) & 3];
            else if (r < 8)  nab = gcode[(gidx(m_ab) + 3) & 3];
            else if (r == 8) nab = gcode[(gidx(m_ab) + 2) & 3];
            else             nab = m_ab;
            move(nab, ($urandom_range(0, 4) == 0), $urandom, ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of an A filter count.
        load(32'hDEAD_BEEF);
        ENC_A = ~m_ab[1];
        for (int i = 0; i < 5; i++) tick();
        resetn = 1'b0;
        #1;
        m_pos = 32'd0;
        m_dir = 1'b0;
        m_err = 1'b0;
        m_ab  = {ENC_A, ENC_B};
        check_all("midrst");
        check("midrst_step", 64'(step), 64'(0));
        check("midrst_ready", 64'(ready), 64'(0));
        tick();
        resetn = 1'b1;
        tick();
        check("rel_ready1", 64'(ready), 64'(0));
        pos_load = 1'b1;
        pos_val  = 32'h0000_0055;
        tick();
        pos_load = 1'b0;
        m_pos    = 32'h0000_0055;
        check("rel_load", 64'(position), 64'(m_pos));
        check("rel_ready2", 64'(ready), 64'(0));
        for (int i = 3; i <= 12; i++) begin
            tick();
            check("rel_ready", 64'(ready), 64'(1));
            check("rel_step", 64'(step), 64'(0));
            check_all("rel");
        end
        move(gcode[(gidx(m_ab) + 1) & 3], 0, 32'd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/quad_encoder.md
QUAD_ENCODER -- requirements
Module: quad_encoder

Interface
REQ-001 The block SHALL have parameter POS_WIDTH, default 32: width of the signed position counter.
REQ-002 The block SHALL have parameter FILTER_CYCLES, default 4, legal range 1..15: consecutive stable cycles required to accept a channel level change.
REQ-003 The block SHALL have port CLK, input, 1: the single system clock; all state is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have ports ENC_A and ENC_B, input, 1 each: raw asynchronous encoder pad inputs.
REQ-006 The block SHALL have port pos_load, input, 1: loads pos_val into position this cycle.
REQ-007 The block SHALL have port pos_val, input, POS_WIDTH: value for pos_load.
REQ-008 The block SHALL have port clr_err, input, 1: clears the sticky error flag.
REQ-009 The block SHALL have port position, output, POS_WIDTH: signed accumulated count, registered.
REQ-010 The block SHALL have port step, output, 1: one-cycle pulse per accepted quadrature edge.
REQ-011 The block SHALL have port dir, output, 1: direction of the most recent step, 1 = forward.
REQ-012 The block SHALL have port err, output, 1: sticky illegal-transition flag.
REQ-013 The block SHALL have port ready, output, 1: high once the decoder is in RUN.

Function
REQ-014 ENC_A and ENC_B SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Each channel SHALL have an independent glitch filter: a counter increments each cycle the synced level differs from the filtered level, clears whenever they match, and the filtered level takes the synced level on the FILTER_CYCLES-th consecutive mismatch cycle.
REQ-016 Control FSM states SHALL be SYNC_WAIT, PRIME and RUN; reset enters SYNC_WAIT.
REQ-017 SYNC_WAIT SHALL last exactly 2 cycles, then go to PRIME.
REQ-018 PRIME SHALL last 1 cycle: filtered levels and the previous-state register load directly from the synced levels, with no step and no error; next state RUN.
REQ-019 In RUN the decoder SHALL compare the filtered state {A,B} with the registered previous state each cycle.
REQ-020 Forward sequence SHALL be 00->10->11->01->00: each such transition increments position by 1, pulses step, sets dir=1.
REQ-021 Reverse sequence 00->01->11->10->00 SHALL decrement position by 1, pulse step, set dir=0.
REQ-022 A transition with both bits changed in one cycle SHALL set err, leave position and dir unchanged, and produce no step.
REQ-023 Position SHALL wrap modulo 2^POS_WIDTH in both directions (max+1 -> min, min-1 -> max).
REQ-024 Latency: a clean pad edge held stable SHALL change position exactly 2+FILTER_CYCLES+1 CLK rising edges after the input change (7 at default).
REQ-025 pos_load SHALL take priority over a simultaneous step: position = pos_val; step and dir still reflect the decoded edge.
REQ-026 pos_load SHALL be honoured in every FSM state.
REQ-027 err set and clr_err in the same cycle SHALL leave err = 1.
REQ-028 ready SHALL be 1 exactly while the FSM is in RUN.

Reset
REQ-029 resetn low SHALL asynchronously force position=0, step=0, dir=0, err=0, ready=0, synchronizers, filters, counters and previous state to 0, and FSM to SYNC_WAIT.
REQ-030 Reset asserted mid-operation SHALL discard any in-progress filter count, and no step SHALL occur until RUN is re-entered.
REQ-031 On release, outputs SHALL hold reset values until RUN; inputs static at 11 through reset release SHALL produce neither err nor step.

Verification
REQ-032 Release reset with ENC_A=ENC_B=1 static -> ready high on cycle 3, err=0, position=0, no step.
REQ-033 Four forward edges spaced 10 cycles apart (00,10,11,01,00) -> position=4, four step pulses, dir=1, first pulse 7 cycles after first edge.
REQ-034 3-cycle pulse on ENC_A at FILTER_CYCLES=4 -> no step, position unchanged.
REQ-035 pos_load with pos_val=0x7FFFFFFF, then one forward edge -> position=0x80000000; one reverse edge -> 0x7FFFFFFF.
REQ-036 Both channels flip 00->11 together -> err=1, position unchanged; clr_err pulse -> err=0; clr_err in the same cycle as a new illegal transition -> err stays 1.
REQ-037 resetn pulsed low while the ENC_A filter count is 3 -> all outputs 0 immediately; after release, no step occurs before ready.
